// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, thresholds, flush and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word fall-through reads; default is registered-read mode.
module sync_fifo_param #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rd_en,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_valid,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(AE_LEVEL);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              wr_acc;
  logic              rd_acc;

  // Explicit wrap compare keeps non-power-of-two depths inside the array.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign full         = (count == FULL_CNT);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_CNT);
  assign almost_empty = (count <= AE_CNT);

  assign wr_acc = wr_en & ~full & ~clr;
  assign rd_acc = rd_en & ~empty & ~clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_acc) rd_ptr <= ptr_inc(rd_ptr);
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wr_en && full)  overflow  <= 1'b1;
      if (rd_en && empty) underflow <= 1'b1;
    end
  end

  // Storage is deliberately not reset or flushed; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= wr_data;
  end

`ifdef SYNC_FIFO_FWFT_EN
  logic [DATA_W-1:0] hold_q;

  // Remember the presented head so rd_data holds once the FIFO drains or is flushed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      hold_q <= '0;
    else if (!empty) hold_q <= mem[rd_ptr];
  end

  assign rd_data  = empty ? hold_q : mem[rd_ptr];
  assign rd_valid = ~empty;
`else
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_acc;
      if (rd_acc) rd_data_q <= mem[rd_ptr];
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench for sync_fifo_param in standard (registered-read) mode.
// A 16-deep instance covers most scenarios; a 5-deep instance covers non-power-of-two wrap.
module tb_sync_fifo_param;

  logic       clk;
  logic       rst_n;
  logic       clr, wr_en, rd_en;
  logic [7:0] wr_data, rd_data;
  logic       rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;

  logic       clr5, wr5, rd5;
  logic [7:0] wd5, rdd5;
  logic       rv5, full5, empty5, af5, ae5, ov5, un5;
  logic [2:0] count5;

  int checks = 0;
  int passed = 0;

  sync_fifo_param #(.DATA_W(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .full(full),
    .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  sync_fifo_param #(.DATA_W(8), .DEPTH(5), .AF_LEVEL(3), .AE_LEVEL(1)) dut5 (
    .clk(clk), .rst_n(rst_n), .clr(clr5), .wr_en(wr5), .wr_data(wd5),
    .rd_en(rd5), .rd_data(rdd5), .rd_valid(rv5), .full(full5),
    .empty(empty5), .almost_full(af5), .almost_empty(ae5),
    .count(count5), .overflow(ov5), .underflow(un5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++; if (count !== 5'd0) $display("[TB] FAIL reset_count got %0d exp 0", count); else passed++;
    checks++; if (empty !== 1'b1) $display("[TB] FAIL reset_empty got %b exp 1", empty); else passed++;
    checks++; if (full !== 1'b0) $display("[TB] FAIL reset_full got %b exp 0", full); else passed++;
    checks++; if (almost_empty !== 1'b1) $display("[TB] FAIL reset_ae got %b exp 1", almost_empty); else passed++;
    checks++; if (almost_full !== 1'b0) $display("[TB] FAIL reset_af got %b exp 0", almost_full); else passed++;
    checks++; if (rd_valid !== 1'b0) $display("[TB] FAIL reset_rd_valid got %b exp 0", rd_valid); else passed++;
    checks++; if (rd_data !== 8'h00) $display("[TB] FAIL reset_rd_data got %h exp 00", rd_data); else passed++;
    checks++; if (overflow !== 1'b0 || underflow !== 1'b0)
      $display("[TB] FAIL reset_errors got ov=%b un=%b exp 0 0", overflow, underflow); else passed++;
    checks++; if (empty5 !== 1'b1 || count5 !== 3'd0)
      $display("[TB] FAIL reset_dut5 got empty=%b count=%0d exp 1 0", empty5, count5); else passed++;
  endtask

  task automatic test_fill_drain();
    int vcnt;
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      step();
      checks++; if (almost_full !== (i + 1 >= 14))
        $display("[TB] FAIL fill_af at count %0d got %b exp %b", i + 1, almost_full, (i + 1 >= 14)); else passed++;
      checks++; if (almost_empty !== (i + 1 <= 2))
        $display("[TB] FAIL fill_ae at count %0d got %b exp %b", i + 1, almost_empty, (i + 1 <= 2)); else passed++;
    end
    wr_en = 1'b0;
    checks++; if (full !== 1'b1 || count !== 5'd16)
      $display("[TB] FAIL fill_full got full=%b count=%0d exp 1 16", full, count); else passed++;
    vcnt = 0;
    for (int i = 0; i < 16; i++) begin
      rd_en = 1'b1;
      step();
      if (rd_valid === 1'b1) vcnt++;
      checks++; if (rd_data !== 8'(i)) $display("[TB] FAIL drain_data[%0d] got %h exp %h", i, rd_data, 8'(i)); else passed++;
    end
    rd_en = 1'b0;
    step();
    if (rd_valid === 1'b1) vcnt++;
    checks++; if (vcnt != 16) $display("[TB] FAIL drain_valid_cycles got %0d exp 16", vcnt); else passed++;
    checks++; if (empty !== 1'b1) $display("[TB] FAIL drain_empty got %b exp 1", empty); else passed++;
    checks++; if (rd_data !== 8'h0F) $display("[TB] FAIL drain_hold got %h exp 0f", rd_data); else passed++;
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'(32'h20 + i);
      step();
    end
    checks++; if (full !== 1'b1) $display("[TB] FAIL ovf_prefill_full got %b exp 1", full); else passed++;
    wr_en = 1'b1; wr_data = 8'hEE; rd_en = 1'b1;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    checks++; if (count !== 5'd15) $display("[TB] FAIL ovf_count got %0d exp 15", count); else passed++;
    checks++; if (overflow !== 1'b1) $display("[TB] FAIL ovf_flag got %b exp 1", overflow); else passed++;
    checks++; if (rd_data !== 8'h20) $display("[TB] FAIL ovf_read got %h exp 20", rd_data); else passed++;
    for (int i = 0; i < 15; i++) begin
      rd_en = 1'b1;
      step();
      checks++; if (rd_data !== 8'(32'h21 + i))
        $display("[TB] FAIL ovf_drain[%0d] got %h exp %h", i, rd_data, 8'(32'h21 + i)); else passed++;
    end
    rd_en = 1'b0;
    step();
    checks++; if (empty !== 1'b1 || overflow !== 1'b1)
      $display("[TB] FAIL ovf_sticky got empty=%b ov=%b exp 1 1", empty, overflow); else passed++;
    clr = 1'b1;
    step();
    clr = 1'b0;
    checks++; if (overflow !== 1'b0) $display("[TB] FAIL ovf_clr got %b exp 0", overflow); else passed++;
  endtask

  task automatic test_underflow();
    rd_en = 1'b1; wr_en = 1'b1; wr_data = 8'h5A;
    step();
    wr_en = 1'b0;
    checks++; if (count !== 5'd1) $display("[TB] FAIL unf_count got %0d exp 1", count); else passed++;
    checks++; if (underflow !== 1'b1) $display("[TB] FAIL unf_flag got %b exp 1", underflow); else passed++;
    checks++; if (rd_valid !== 1'b0) $display("[TB] FAIL unf_rd_valid got %b exp 0", rd_valid); else passed++;
    step();
    rd_en = 1'b0;
    checks++; if (rd_data !== 8'h5A || rd_valid !== 1'b1)
      $display("[TB] FAIL unf_read got %h v=%b exp 5a 1", rd_data, rd_valid); else passed++;
    checks++; if (count !== 5'd0 || underflow !== 1'b1)
      $display("[TB] FAIL unf_sticky got count=%0d un=%b exp 0 1", count, underflow); else passed++;
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = 8'(32'h40 + i);
      step();
    end
    checks++; if (count !== 5'd3) $display("[TB] FAIL sim_prefill got %0d exp 3", count); else passed++;
    for (int k = 0; k < 10; k++) begin
      wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'(32'h43 + k);
      step();
      checks++; if (rd_data !== 8'(32'h40 + k) || rd_valid !== 1'b1)
        $display("[TB] FAIL sim_data[%0d] got %h v=%b exp %h 1", k, rd_data, rd_valid, 8'(32'h40 + k)); else passed++;
      checks++; if (count !== 5'd3) $display("[TB] FAIL sim_count[%0d] got %0d exp 3", k, count); else passed++;
    end
    wr_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rd_en = 1'b1;
      step();
      checks++; if (rd_data !== 8'(32'h4A + k))
        $display("[TB] FAIL sim_tail[%0d] got %h exp %h", k, rd_data, 8'(32'h4A + k)); else passed++;
    end
    rd_en = 1'b0;
    step();
    checks++; if (empty !== 1'b1) $display("[TB] FAIL sim_empty got %b exp 1", empty); else passed++;
  endtask

  task automatic test_clr();
    for (int i = 0; i < 10; i++) begin
      wr_en = 1'b1; wr_data = 8'(32'h60 + i);
      step();
    end
    wr_en = 1'b0; rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    checks++; if (count !== 5'd9 || rd_data !== 8'h60)
      $display("[TB] FAIL clr_setup got count=%0d data=%h exp 9 60", count, rd_data); else passed++;
    checks++; if (underflow !== 1'b1) $display("[TB] FAIL clr_pre_underflow got %b exp 1", underflow); else passed++;
    clr = 1'b1; wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'hAA;
    step();
    clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    checks++; if (count !== 5'd0 || empty !== 1'b1)
      $display("[TB] FAIL clr_count got count=%0d empty=%b exp 0 1", count, empty); else passed++;
    checks++; if (underflow !== 1'b0 || overflow !== 1'b0)
      $display("[TB] FAIL clr_errors got ov=%b un=%b exp 0 0", overflow, underflow); else passed++;
    checks++; if (rd_valid !== 1'b0 || rd_data !== 8'h60)
      $display("[TB] FAIL clr_read got v=%b data=%h exp 0 60", rd_valid, rd_data); else passed++;
    step();
    checks++; if (count !== 5'd0) $display("[TB] FAIL clr_ignored_write got %0d exp 0", count); else passed++;
  endtask

  task automatic test_back_to_back();
    int exp_cnt;
    exp_cnt = 0;
    for (int i = 1; i <= 5; i++) begin
      wr5 = 1'b1; wd5 = 8'(i);
      step();
      exp_cnt++;
    end
    wr5 = 1'b0;
    checks++; if (full5 !== 1'b1 || count5 !== 3'd5)
      $display("[TB] FAIL wrap_full got full=%b count=%0d exp 1 5", full5, count5); else passed++;
    rd5 = 1'b1;
    step();
    exp_cnt--;
    checks++; if (rdd5 !== 8'd1) $display("[TB] FAIL wrap_data[1] got %0d exp 1", rdd5); else passed++;
    for (int i = 6; i <= 12; i++) begin
      wr5 = 1'b1; rd5 = 1'b1; wd5 = 8'(i);
      step();
      checks++; if (rdd5 !== 8'(i - 4)) $display("[TB] FAIL wrap_data[%0d] got %0d exp %0d", i - 4, rdd5, i - 4); else passed++;
      checks++; if (count5 !== 3'(exp_cnt)) $display("[TB] FAIL wrap_count got %0d exp %0d", count5, exp_cnt); else passed++;
    end
    wr5 = 1'b0;
    for (int i = 9; i <= 12; i++) begin
      rd5 = 1'b1;
      step();
      checks++; if (rdd5 !== 8'(i)) $display("[TB] FAIL wrap_data[%0d] got %0d exp %0d", i, rdd5, i); else passed++;
    end
    rd5 = 1'b0;
    step();
    checks++; if (empty5 !== 1'b1 || ov5 !== 1'b0 || un5 !== 1'b0)
      $display("[TB] FAIL wrap_end got empty=%b ov=%b un=%b exp 1 0 0", empty5, ov5, un5); else passed++;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_data = 8'(32'h71 + i);
      step();
    end
    wr_en = 1'b0; rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    checks++; if (count !== 5'd7 || rd_valid !== 1'b1 || rd_data !== 8'h71)
      $display("[TB] FAIL arst_setup got count=%0d v=%b data=%h exp 7 1 71", count, rd_valid, rd_data); else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (count !== 5'd0 || empty !== 1'b1)
      $display("[TB] FAIL arst_count got count=%0d empty=%b exp 0 1", count, empty); else passed++;
    checks++; if (rd_valid !== 1'b0 || rd_data !== 8'h00)
      $display("[TB] FAIL arst_read got v=%b data=%h exp 0 00", rd_valid, rd_data); else passed++;
    #1;
    rst_n = 1'b1;
    step();
    checks++; if (empty !== 1'b1 || count !== 5'd0)
      $display("[TB] FAIL arst_after got empty=%b count=%0d exp 1 0", empty, count); else passed++;
  endtask

  initial begin
    rst_n = 1'b0;
    clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = 8'h00;
    clr5 = 1'b0; wr5 = 1'b0; rd5 = 1'b0; wd5 = 8'h00;
    #1;
    test_reset();
    #3;
    rst_n = 1'b1;
    step();
    $display("[TB] fill and drain");
    test_fill_drain();
    $display("[TB] overflow");
    test_overflow();
    $display("[TB] underflow");
    test_underflow();
    $display("[TB] simultaneous access");
    test_simultaneous();
    $display("[TB] flush");
    test_clr();
    $display("[TB] non-power-of-two wrap");
    test_back_to_back();
    $display("[TB] async reset");
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
